// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - execute-stage and mul/div unit signal bundle for muldiv_ctrl
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 op_valid;
  logic [3:0]           op;
  logic [WIDTH-1:0]     rs_val;
  logic [WIDTH-1:0]     rt_val;
  logic                 flush;
  logic                 stall;
  logic [WIDTH-1:0]     rd_data;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic                 busy;
  logic                 mul_start;
  logic                 mul_signd;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_ready;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 div_start;
  logic                 div_signd;
  logic [WIDTH-1:0]     div_a;
  logic [WIDTH-1:0]     div_b;
  logic                 div_ready;
  logic [WIDTH-1:0]     div_quot;
  logic [WIDTH-1:0]     div_rem;

  modport slave (
    input  op_valid, op, rs_val, rt_val, flush,
    input  mul_ready, mul_product, div_ready, div_quot, div_rem,
    output stall, rd_data, hi, lo, busy,
    output mul_start, mul_signd, mul_a, mul_b,
    output div_start, div_signd, div_a, div_b
  );

  modport master (
    output op_valid, op, rs_val, rt_val, flush,
    output mul_ready, mul_product, div_ready, div_quot, div_rem,
    input  stall, rd_data, hi, lo, busy,
    input  mul_start, mul_signd, mul_a, mul_b,
    input  div_start, div_signd, div_a, div_b
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer with pipeline hazard stall
// Defining MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU with a MACC accumulate state.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSTART,
    S_MWAIT,
    S_DSTART,
    S_DWAIT
`ifdef MULDIV_MADD_EN
    , S_MACC
`endif
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_mul_start;
  logic               r_mul_signd;
  logic               r_div_start;
  logic               r_div_signd;
`ifdef MULDIV_MADD_EN
  logic               r_acc;
  logic               r_sub;
  logic [2*WIDTH-1:0] r_prod;
`endif
  logic               w_op_real;

  // Unknown opcodes behave as NOP, so they never raise a hazard stall.
  always_comb begin
    w_op_real = 1'b0;
    case (bus.op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: w_op_real = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_op_real = 1'b1;
`endif
      default: w_op_real = 1'b0;
    endcase
  end

  assign bus.stall     = bus.op_valid && w_op_real && (r_state != S_IDLE);
  assign bus.rd_data   = (bus.op == OP_MFLO) ? r_lo : r_hi;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.busy      = r_busy;
  assign bus.mul_start = r_mul_start;
  assign bus.mul_signd = r_mul_signd;
  assign bus.mul_a     = r_opa;
  assign bus.mul_b     = r_opb;
  assign bus.div_start = r_div_start;
  assign bus.div_signd = r_div_signd;
  assign bus.div_a     = r_opa;
  assign bus.div_b     = r_opb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_mul_start <= 1'b0;
      r_mul_signd <= 1'b0;
      r_div_start <= 1'b0;
      r_div_signd <= 1'b0;
`ifdef MULDIV_MADD_EN
      r_acc       <= 1'b0;
      r_sub       <= 1'b0;
      r_prod      <= '0;
`endif
    end else if (bus.flush) begin
      // The unit keeps iterating; its stale result is ignored until the next start.
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                r_opa       <= bus.rs_val;
                r_opb       <= bus.rt_val;
                r_mul_signd <= (bus.op == OP_MULT);
                r_mul_start <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= S_MSTART;
`ifdef MULDIV_MADD_EN
                r_acc       <= 1'b0;
`endif
              end
`ifdef MULDIV_MADD_EN
              OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                r_opa       <= bus.rs_val;
                r_opb       <= bus.rt_val;
                r_mul_signd <= (bus.op == OP_MADD) || (bus.op == OP_MSUB);
                r_mul_start <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= S_MSTART;
                r_acc       <= 1'b1;
                r_sub       <= (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
              end
`endif
              OP_DIV, OP_DIVU: begin
                r_opa       <= bus.rs_val;
                r_opb       <= bus.rt_val;
                r_div_signd <= (bus.op == OP_DIV);
                r_div_start <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= S_DSTART;
              end
              OP_MTHI: r_hi <= bus.rs_val;
              OP_MTLO: r_lo <= bus.rs_val;
              default: ;
            endcase
          end
        end
        S_MSTART: begin
          r_mul_start <= 1'b0;
          r_state     <= S_MWAIT;
        end
        S_MWAIT: begin
          if (bus.mul_ready) begin
`ifdef MULDIV_MADD_EN
            if (r_acc) begin
              r_prod  <= bus.mul_product;
              r_state <= S_MACC;
            end else
`endif
            begin
              r_hi    <= bus.mul_product[2*WIDTH-1:WIDTH];
              r_lo    <= bus.mul_product[WIDTH-1:0];
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        S_DSTART: begin
          r_div_start <= 1'b0;
          r_state     <= S_DWAIT;
        end
        S_DWAIT: begin
          if (bus.div_ready) begin
            r_lo    <= bus.div_quot;
            r_hi    <= bus.div_rem;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
`ifdef MULDIV_MADD_EN
        S_MACC: begin
          {r_hi, r_lo} <= r_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl with behavioural mul/div units
module tb_muldiv_ctrl;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mcnt;
  int   dcnt;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  res_t        q_res[$];
  logic [31:0] q_rd[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();
  muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({32'b0, a}) * longint'({32'b0, b});
    return p;
  endfunction

  // Returns {remainder, quotient}; signed division truncates toward zero.
  function automatic logic [63:0] divres(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'b0, a}) / longint'({32'b0, b});
      r = longint'({32'b0, a}) % longint'({32'b0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit is_result(input logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return (op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU);
`else
    return (op >= OP_MULT && op <= OP_DIVU);
`endif
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier unit: ready immediately for a zero operand, otherwise 33 cycles after start.
  always @(posedge clk) begin
    if (rst) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= '0;
      mcnt            <= 0;
    end else if (bus.mul_start) begin
      bus.mul_product <= prod(bus.mul_a, bus.mul_b, bus.mul_signd);
      bus.mul_ready   <= (bus.mul_a == 32'd0) || (bus.mul_b == 32'd0);
      mcnt            <= ((bus.mul_a == 32'd0) || (bus.mul_b == 32'd0)) ? 0 : 32;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) bus.mul_ready <= 1'b1;
    end
  end

  // Divider unit with a randomised latency per operation.
  always @(posedge clk) begin
    if (rst) begin
      bus.div_ready <= 1'b0;
      bus.div_quot  <= '0;
      bus.div_rem   <= '0;
      dcnt          <= 0;
    end else if (bus.div_start) begin
      {bus.div_rem, bus.div_quot} <= divres(bus.div_a, bus.div_b, bus.div_signd);
      bus.div_ready <= 1'b0;
      dcnt          <= int'($urandom_range(1, 6));
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) bus.div_ready <= 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT completes an op or serves MFHI/MFLO.
  initial begin
    res_t e;
    logic pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pb && !bus.busy) begin
        check("completion_queued", q_res.size() > 0, 1);
        if (q_res.size() > 0) begin
          e = q_res.pop_front();
          check("hi_after_op", bus.hi, e.hi);
          check("lo_after_op", bus.lo, e.lo);
          if (e.cyc >= 0) check("result_cycle", cyc, e.cyc);
        end
      end
      if (!rst && bus.op_valid && !bus.flush && !bus.stall &&
          (bus.op == OP_MFHI || bus.op == OP_MFLO)) begin
        check("mf_queued", q_rd.size() > 0, 1);
        if (q_rd.size() > 0) check("rd_data", bus.rd_data, q_rd.pop_front());
      end
      pb = bus.busy;
    end
  end

  // mode 0: normal, 1: will be flushed, 2: will be reset. lat < 0 means latency unchecked.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode, input int lat, output int t_acc);
    bit          done;
    logic [63:0] hl;
    res_t        e;
    done  = 1'b0;
    t_acc = -1;
    bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.op_valid = 1'b1;
    if (op == OP_MFHI) q_rd.push_back(m_hi);
    else if (op == OP_MFLO) q_rd.push_back(m_lo);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!bus.stall) done = 1'b1;
    end
    check("accepted_in_time", done, 1);
    if (done) begin
      t_acc = cyc;
      if (is_result(op)) begin
        hl = {m_hi, m_lo};
        case (op)
          OP_MULT:  hl = prod(a, b, 1'b1);
          OP_MULTU: hl = prod(a, b, 1'b0);
          OP_DIV:   hl = divres(a, b, 1'b1);
          OP_DIVU:  hl = divres(a, b, 1'b0);
          OP_MADD:  hl = hl + prod(a, b, 1'b1);
          OP_MADDU: hl = hl + prod(a, b, 1'b0);
          OP_MSUB:  hl = hl - prod(a, b, 1'b1);
          OP_MSUBU: hl = hl - prod(a, b, 1'b0);
          default:  ;
        endcase
        if (mode == 1) begin
          e.hi = m_hi; e.lo = m_lo; e.cyc = -1;
        end else if (mode == 2) begin
          e.hi = '0; e.lo = '0; e.cyc = -1;
          m_hi = '0; m_lo = '0;
        end else begin
          e.hi = hl[63:32]; e.lo = hl[31:0]; e.cyc = (lat < 0) ? -1 : t_acc + lat;
          m_hi = hl[63:32]; m_lo = hl[31:0];
        end
        q_res.push_back(e);
      end else if (op == OP_MTHI) begin
        m_hi = a;
      end else if (op == OP_MTLO) begin
        m_lo = a;
      end
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_in_time", bus.busy, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          t2;
    int          lat;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = OP_NOP; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_div_start", bus.div_start, 0);
    check("rst_signd", {bus.mul_signd, bus.div_signd}, 0);
    step();

    // Signed multiply, start pulse timing and stall until capture.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 35, t);
    @(negedge clk);
    check("mul_start_pulse", bus.mul_start, 1);
    check("mul_signd", bus.mul_signd, 1);
    check("mul_a_latched", bus.mul_a, 32'hFFFF_FFFE);
    check("busy_during_mul", bus.busy, 1);
    @(negedge clk);
    check("mul_start_one_cycle", bus.mul_start, 0);
    step();
    issue(OP_MFHI, '0, '0, 0, -1, t2);
    check("mfhi_stalled_to_capture", t2, t + 35);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // Zero operand: fast path.
    issue(OP_MULTU, 32'd0, 32'h1234, 0, 3, t);
    wait_idle();
    check("multu_zero_hi", bus.hi, 0);
    check("multu_zero_lo", bus.lo, 0);

    // Divide followed back-to-back by MFLO.
    issue(OP_DIVU, 32'd100, 32'd7, 0, -1, t);
    issue(OP_MFLO, '0, '0, 0, -1, t2);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    issue(OP_MTHI, 32'hDEAD_BEEF, '0, 0, -1, t);
    issue(OP_MFHI, '0, '0, 0, -1, t2);
    check("mfhi_no_stall", t2, t + 1);

    // Flush in MWAIT leaves HI/LO untouched.
    issue(OP_MULT, 32'd5, 32'd5, 1, -1, t);
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", bus.busy, 0);
    check("flush_hi", bus.hi, 32'hDEAD_BEEF);
    check("flush_lo", bus.lo, 32'd14);
    step();
    issue(OP_MULT, 32'd2, 32'd3, 0, 35, t);
    wait_idle();
    check("mult_after_flush_lo", bus.lo, 32'd6);

    // Reset mid-operation.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 2, -1, t);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_hi", bus.hi, 0);
    check("rst_mid_lo", bus.lo, 0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

`ifdef MULDIV_MADD_EN
    issue(OP_MTLO, 32'd10, '0, 0, -1, t);
    issue(OP_MTHI, 32'd0, '0, 0, -1, t);
    issue(OP_MADD, 32'd3, 32'd4, 0, 36, t);
    wait_idle();
    check("madd_lo", bus.lo, 32'd22);
    check("madd_hi", bus.hi, 32'd0);
    issue(OP_MSUBU, 32'd1, 32'd30, 0, 36, t);
    wait_idle();
    check("msubu_lo", bus.lo, 32'hFFFF_FFF8);
    check("msubu_hi", bus.hi, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom());
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom());
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ((rop == OP_DIV || rop == OP_DIVU) && rb == 32'd0) rb = 32'd1;
      lat = -1;
      if (rop == OP_MULT || rop == OP_MULTU) lat = (ra == 0 || rb == 0) ? 3 : 35;
`ifdef MULDIV_MADD_EN
      if (rop >= OP_MADD && rop <= OP_MSUBU) lat = (ra == 0 || rb == 0) ? 4 : 36;
`endif
      issue(rop, ra, rb, 0, lat, t);
      repeat ($urandom_range(0, 2)) step();
    end

    wait_idle();
    repeat (3) step();
    check("res_queue_drained", q_res.size(), 0);
    check("rd_queue_drained", q_rd.size(), 0);
    check("final_hi", bus.hi, m_hi);
    check("final_lo", bus.lo, m_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the CPU's HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the execute stage and latches operands. It drives the iterative multiplier (32-step shift-add) and the iterative divider with start pulses, and captures their results into HI/LO. It stalls the pipeline while a HI/LO hazard exists.

Parameters:
WIDTH, 32, register width; equals CPU_REG_WIDTH. Product and HI:LO are 2*WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
op_valid  in  1  op presented this cycle
op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-12 see Optional Feature
rs_val  in  WIDTH  operand A / MTHI/MTLO data
rt_val  in  WIDTH  operand B
flush  in  1  cancel in-flight op
stall  out  1  hold execute stage
rd_data  out  WIDTH  MFHI/MFLO result (combinational from HI/LO)
hi, lo  out  WIDTH each  architectural HI/LO
busy  out  1  state != IDLE
mul_start, mul_signd  out  1 each  multiplier control
mul_a, mul_b  out  WIDTH each  multiplicand/multiplier, held stable from START to capture
mul_ready  in  1  multiplier done
mul_product  in  2*WIDTH  product
div_start, div_signd  out  1 each  divider control
div_a, div_b  out  WIDTH each  dividend/divisor, held stable
div_ready  in  1  divider done
div_quot, div_rem  in  WIDTH each  quotient, remainder

Behaviour:
- Reset: state IDLE; hi, lo, opa, opb = 0; all start/signd = 0; stall = 0; busy = 0.
- States: IDLE, MSTART, MWAIT, DSTART, DWAIT.
- IDLE, op_valid, op MULT/MULTU: latch rs→opa, rt→opb, signd = (op==MULT); go to MSTART. DIV/DIVU go to DSTART in the same way.
- MSTART: mul_start = 1 for exactly one cycle; go to MWAIT. DSTART/DWAIT follow the same pattern.
- MWAIT: when mul_ready = 1, lo ← product[WIDTH-1:0] and hi ← product[2W-1:W]; go to IDLE. DWAIT on div_ready: lo ← quot, hi ← rem.
- mul_ready is ignored during MSTART. The multiplier deasserts ready while start is high.
- Latency, MULT with nonzero operands accepted in cycle T: mul_start in T+1, mul_ready in T+34, HI/LO visible in T+35. With a zero operand: ready in T+2, HI/LO visible in T+3.
- MTHI/MTLO in IDLE: write hi/lo at the clock edge, no stall.
- MFHI/MFLO in IDLE: rd_data = hi/lo, no stall.
- stall = op_valid && op != NOP && state != IDLE. A stalled op is not accepted. Upstream re-presents it and it is accepted on the first IDLE cycle.
- Capture-cycle edge: stall is still 1 in the capture cycle. The next cycle is IDLE, and MFHI returns the new value.
- flush: any state → IDLE next edge; hi/lo are not written. flush has priority over ready capture and over acceptance in the same cycle. The unit's internal iteration is left running and is overridden by the next start.
- Divide by zero: no special case; whatever the divider returns is written.
- op values 9-15 without the feature are NOP.
- rst mid-operation: immediate return to reset values; the pending result is discarded.

Optional Feature:
MULDIV_MADD_EN. When defined, ops 9 MADD, 10 MADDU, 11 MSUB and 12 MSUBU are sequenced like MULT/MULTU.
- At capture, an extra state MACC follows: {hi,lo} ← {hi,lo} ± product, modulo 2^(2W). Latency is one cycle longer than MULT.
- When not defined, these codes are NOP and no MACC state exists.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 → mul_start pulse T+1, stall held until capture; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU rs=0, rt=0x1234 → hi=0, lo=0 visible at T+3.
- DIVU rs=100, rt=7 → lo=14, hi=2. Back-to-back MFLO stalls until capture, then rd_data=14.
- MTHI 0xDEADBEEF then MFHI next cycle → no stall, rd_data=0xDEADBEEF.
- MULT 5×5 with flush asserted in MWAIT → IDLE next cycle, hi/lo unchanged. A following MULT 2×3 → lo=6.
- MULTU 0xFFFFFFFF×2 with rst pulsed mid-operation → hi=lo=0, busy=0. With MULDIV_MADD_EN: hi:lo=0:10, MADD 3×4 → lo=22, hi=0.
